uart_tx_arbiter: RTL and testbench

- Shares one 8N1 UART transmit line between NUM_REQ byte requesters, such as a status beacon, a loopback echo and a debug dump.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Owns the serializer and enforces a configurable idle gap between frames.
- Sits between on-chip byte producers and the board uart_tx pin.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_serializer.sv | 99 +++++++++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - serializer state encoding, frame constants and baud helper
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} uart_state_e;

  localparam int FRAME_BITS = 10;

  function automatic int bit_period(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 frame sequencer (start, 8 data LSB first, stop, idle gap)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 69,
  parameter int GAP_BITS   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       idle_o
);

  localparam int TW = $clog2(BIT_PERIOD * 16);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
  localparam logic [3:0]    DATA_LAST = 4'(FRAME_BITS - 3);
  // The IDLE accept cycle is the final idle-high cycle of a frame, so the
  // closing phase runs one cycle short to keep a (10+GAP_BITS)*BIT_PERIOD period.
  localparam logic [TW-1:0] STOP_LAST = (GAP_BITS == 0) ? TW'(BIT_PERIOD - 2) : BIT_LAST;
  localparam logic [TW-1:0] GAP_LAST  = (GAP_BITS == 0) ? '0 : TW'(GAP_BITS * BIT_PERIOD - 2);

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_o      = 1'b1;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (load_i) begin
          state_d   = START;
          shreg_d   = data_i;
          bit_idx_d = '0;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_o = shreg_q[0];
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (timer_q == STOP_LAST) begin
          timer_d = '0;
          state_d = (GAP_BITS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  assign idle_o = (state_q == IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART tx line among NUM_REQ byte sources
// UART_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 8_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int NUM_REQ    = 4,
  parameter int GAP_BITS   = 1,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  localparam int BIT_PERIOD = bit_period(CLOCK_FREQ, BAUD_RATE);

  logic          ser_idle;
  logic          load;
  logic          any_valid;
  logic [IW-1:0] winner;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [7:0]    sel_data;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        winner    = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
    return IW'((int'(base) + offset) % NUM_REQ);
  endfunction

  // Walk offsets from far to near so the requester closest to rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(rr_ptr_q, k)]) begin
        any_valid = 1'b1;
        winner    = rr_index(rr_ptr_q, k);
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (rst_n && ser_idle && any_valid) req_ready[winner] = 1'b1;
  end

  assign load     = |(req_valid & req_ready);
  assign sel_data = req_data[int'(winner) * 8 +: 8];

  always_comb begin
    grant_id_d = grant_id_q;
    if (load) grant_id_d = winner;
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_id_q <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      grant_id_q <= grant_id_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  uart_tx_serializer #(
    .BIT_PERIOD(BIT_PERIOD),
    .GAP_BITS  (GAP_BITS)
  ) u_serializer (
    .clk_i (clk),
    .rst_ni(rst_n),
    .load_i(load),
    .data_i(sel_data),
    .tx_o  (uart_tx),
    .idle_o(ser_idle)
  );

  assign busy     = ~ser_idle;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench: reference arbitration/timing model plus a line decoder
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int BP    = 69;
  localparam int FRAME = 759;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        uart_tx;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(
    .CLOCK_FREQ(8_000_000),
    .BAUD_RATE (115200),
    .NUM_REQ   (4),
    .GAP_BITS  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;
  frame_t exp_q[$];

  bit [3:0]   pend = '0;
  bit [3:0]   hold_mask = '0;
  logic [7:0] pbyte [N];
  logic       rst_cmd = 1'b0;
  int m_ptr = 0, m_grant = 0, m_last = -1, m_free = 0;
  logic [3:0] s_ready;
  logic       s_busy, s_tx;
  logic [1:0] s_grant;
  int         s_t;
  bit         accepted;
  bit         mon_active = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input bit [3:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step();
    int w;
    logic [3:0] er;
    @(negedge clk);
    s_t = cyc;
    rst_n = rst_cmd;
    req_valid = pend;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = pbyte[i];
    #1;
    s_ready = req_ready; s_busy = busy; s_tx = uart_tx; s_grant = grant_id;
`ifdef UART_ARB_FIXED_PRIO_EN
    w = pick(pend, 0);
`else
    w = pick(pend, m_ptr);
`endif
    er = (rst_n && s_t >= m_free && w >= 0) ? (4'b0001 << w) : 4'b0000;
    chk("req_ready", s_ready, er);
    chk("busy", s_busy, (s_t > m_last && s_t < m_free));
    chk("grant_id", s_grant, m_grant);
    accepted = 0;
    if (!rst_n) begin
      m_ptr = 0; m_grant = 0; m_last = -1; m_free = 0;
      exp_q.delete();
    end else if (er != 0) begin
      accepted = 1;
      exp_q.push_back('{pbyte[w], s_t + 1});
      m_ptr = (w + 1) % N; m_grant = w; m_last = s_t; m_free = s_t + FRAME;
      pend[w] = hold_mask[w];
      pbyte[w] = 8'($urandom);
    end
  endtask

  initial begin : monitor
    frame_t e;
    logic [7:0] got;
    bit abort;
    int j;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_start at cycle %0d: got start bit, expected idle line", cyc);
          repeat (FRAME) @(posedge clk);
        end else begin
          e = exp_q.pop_front();
          chk("start_cycle", cyc, e.start);
          mon_active = 1; abort = 0; got = '0;
          for (int c = 1; c <= 9 * BP + BP / 2 && !abort; c++) begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) abort = 1;
            else if (c % BP == BP / 2) begin
              j = c / BP;
              if (j == 9) chk("stop_bit", uart_tx, 1'b1);
              else got[j-1] = uart_tx;
            end
          end
          if (!abort) chk("frame_data", got, e.data);
          mon_active = 0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: bench still running after 200000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int rr_exp[5];
    int k, n, prev;
    logic [9:0] a5_line;
    logic [3:0] both_exp;
`ifdef UART_ARB_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0, 0};
    both_exp = 4'b0010;
`else
    rr_exp = '{0, 1, 2, 3, 0};
    both_exp = 4'b0100;
`endif
    a5_line = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < N; i++) pbyte[i] = 8'($urandom);
    pend = 4'b1111; hold_mask = 4'b1111; rst_cmd = 1'b0;
    @(posedge clk);
    repeat (5) begin
      step();
      chk("rst_tx", s_tx, 1'b1);
      chk("rst_ready", s_ready, 4'b0000);
      chk("rst_busy", s_busy, 1'b0);
    end

    // release with all valid held: rotation 0,1,2,3,0 one frame apart
    rst_cmd = 1'b1; k = 0; prev = 0;
    for (int c = 0; c < 5000 && k < 5; c++) begin
      step();
      if (c == 0) chk("release_ready", s_ready, 4'b0001);
      if (accepted) begin
        chk("rr_grant", s_ready, 4'b0001 << rr_exp[k]);
        if (k > 0) chk("rr_spacing", s_t - prev, FRAME);
        prev = s_t; k++;
      end
    end
    chk("rr_count", k, 5);
    hold_mask = '0; pend = '0;
    repeat (FRAME + 40) step();

    // single 0xA5 frame from requester 1
    pbyte[1] = 8'hA5; pend = 4'b0010;
    step();
    chk("a5_ready", s_ready, 4'b0010);
    n = 0;
    do begin
      step(); n++;
      if (n == 1) chk("a5_grant", s_grant, 2'd1);
      if ((n - 1) % BP == BP / 2 && (n - 1) / BP < 10) chk("a5_line", s_tx, a5_line[(n - 1) / BP]);
    end while (s_busy && n < 2000);
    chk("busy_fall", n, FRAME);

    // pointer wrap and skip
    pend = 4'b0100; step(); chk("wrap_g2", s_ready, 4'b0100);
    repeat (FRAME) step();
    pend = 4'b0010; step(); chk("wrap_g1", s_ready, 4'b0010);
    repeat (FRAME) step();
    pbyte[1] = 8'h00; pbyte[2] = 8'h00;
    pend = 4'b0110; step(); chk("wrap_next", s_ready, both_exp);

    // reset 300 cycles into the frame, line is mid data bit (low)
    repeat (299) step();
    rst_cmd = 1'b0; step(); chk("pre_reset_tx", s_tx, 1'b0);
    step();
    chk("mid_reset_tx", s_tx, 1'b1);
    chk("mid_reset_busy", s_busy, 1'b0);
    pend = 4'b1111; rst_cmd = 1'b1;
    step(); chk("post_reset_grant", s_ready, 4'b0001);

    // randomized traffic, dense then sparse, with occasional withdrawals
    for (int c = 0; c < 30000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, (c < 15000) ? 300 : 3000) == 0) begin
          pend[i] = 1'b1; pbyte[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 999) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step();
    end
    pend = '0;
    repeat (FRAME + 100) step();
    chk("queue_drained", exp_q.size(), 0);
    chk("monitor_idle", mon_active, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
